// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle KGP-RISC successor core.
// Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over a
// single unified memory port. The memory can stall any request by holding
// mem_ready low.
//
// Memory handshake: the core raises mem_req with mem_we/mem_addr/mem_wdata
// and holds all of them stable until a cycle in which mem_ready=1. That
// cycle completes the transfer, and read data is taken from mem_rdata in the
// same cycle. mem_ready is ignored while mem_req=0.
module multicycle_core #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic            halted
);

   localparam int RW  = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int SW  = $clog2(XLEN);
   localparam int MSB = XLEN - 1;

   localparam logic [5:0] OP_ALU  = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h01;
   localparam logic [5:0] OP_LW   = 6'h02;
   localparam logic [5:0] OP_SW   = 6'h03;
   localparam logic [5:0] OP_BR   = 6'h04;
   localparam logic [5:0] OP_JMP  = 6'h05;
   localparam logic [5:0] OP_HALT = 6'h3F;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t state, next_state;

   // boot keeps mem_req low for one cycle after reset so an aborted request
   // is visibly dropped before the fetch from RESET_PC starts.
   logic            boot;
   logic [XLEN-1:0] pc, a, b, res;
   logic [31:0]     ir;
   logic            flag_z, flag_c, flag_s, flag_v;
   logic [XLEN-1:0] regs [NREGS];

   // Instruction fields
   logic [5:0]      op;
   logic [3:0]      fn;
   logic [4:0]      cond;
   logic [RW-1:0]   rs_idx, rt_idx, rd_idx, wb_idx;
   logic [XLEN-1:0] imm_ext;
   logic            unused_ir;

   assign op      = ir[31:26];
   assign fn      = ir[3:0];
   assign cond    = ir[20:16];
   assign rs_idx  = ir[21 +: RW];
   assign rt_idx  = ir[16 +: RW];
   assign rd_idx  = ir[11 +: RW];
   assign wb_idx  = (op == OP_ALU) ? rd_idx : rt_idx;
   assign imm_ext = {{(XLEN-16){ir[15]}}, ir[15:0]};
   assign unused_ir = ^ir;

   // ALU
   logic [XLEN:0]   sum_ab, sum_ai;
   logic [SW-1:0]   shamt;
   logic [XLEN-1:0] alu_res;
   logic            alu_c, alu_v;
   logic            is_alu, br_taken;

   assign sum_ab = {1'b0, a} + {1'b0, b};
   assign sum_ai = {1'b0, a} + {1'b0, imm_ext};
   assign shamt  = b[SW-1:0];
   assign is_alu = (op == OP_ALU) && !fn[3];

   // ALU result and carry/overflow for R-type and addi
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      if (op == OP_ADDI) begin
         alu_res = sum_ai[MSB:0];
         alu_c   = sum_ai[XLEN];
         alu_v   = (a[MSB] == imm_ext[MSB]) && (alu_res[MSB] != a[MSB]);
      end else begin
         case (fn)
            4'd0: begin
               alu_res = sum_ab[MSB:0];
               alu_c   = sum_ab[XLEN];
               alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            4'd1: begin
               alu_res = a - b;
               alu_c   = (a < b);
               alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            4'd2:    alu_res = a & b;
            4'd3:    alu_res = a | b;
            4'd4:    alu_res = a ^ b;
            4'd5:    alu_res = a << shamt;
            4'd6:    alu_res = a >> shamt;
            4'd7:    alu_res = $unsigned($signed(a) >>> shamt);
            default: alu_res = '0;
         endcase
      end
   end

   // Branch condition selected by the rt field against the registered flags
   always_comb begin
      case (cond)
         5'd0:    br_taken = 1'b1;
         5'd1:    br_taken = flag_z;
         5'd2:    br_taken = !flag_z;
         5'd3:    br_taken = flag_c;
         5'd4:    br_taken = flag_s;
         5'd5:    br_taken = flag_v;
         default: br_taken = 1'b0;
      endcase
   end

   // State register and boot cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         boot  <= 1'b1;
      end else begin
         state <= next_state;
         boot  <= 1'b0;
      end
   end

   // Next state and memory port outputs
   always_comb begin
      next_state = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = pc;
      mem_wdata  = b;
      case (state)
         S_FETCH: begin
            if (!boot) begin
               mem_req = 1'b1;
               if (mem_ready) next_state = S_DECODE;
            end
         end
         S_DECODE: next_state = S_EXEC;
         S_EXEC: begin
            case (op)
               OP_ALU:       next_state = is_alu ? S_WB : S_FETCH;
               OP_ADDI:      next_state = S_WB;
               OP_LW, OP_SW: next_state = S_MEM;
               OP_HALT:      next_state = S_HALT;
               default:      next_state = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_addr = res;
            mem_we   = (op == OP_SW);
            if (mem_ready) next_state = (op == OP_LW) ? S_WB : S_FETCH;
         end
         S_WB:    next_state = S_FETCH;
         S_HALT:  next_state = S_HALT;
         default: next_state = S_FETCH;
      endcase
   end

   assign halted = (state == S_HALT);

   // Datapath registers: PC, IR, operands, result, flags and register file
   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         ir     <= '0;
         a      <= '0;
         b      <= '0;
         res    <= '0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_s <= 1'b0;
         flag_v <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (!boot && mem_ready) begin
                  ir <= mem_rdata[31:0];
                  pc <= pc + XLEN'(4);
               end
            end
            S_DECODE: begin
               a <= regs[rs_idx];
               b <= regs[rt_idx];
            end
            S_EXEC: begin
               if (is_alu || op == OP_ADDI) begin
                  res    <= alu_res;
                  flag_z <= (alu_res == '0);
                  flag_s <= alu_res[MSB];
                  flag_c <= alu_c;
                  flag_v <= alu_v;
               end else if (op == OP_LW || op == OP_SW) begin
                  res <= sum_ai[MSB:0];
               end else if (op == OP_BR) begin
                  if (br_taken) pc <= pc + (imm_ext << 2);
               end else if (op == OP_JMP) begin
                  pc <= {pc[MSB:28], ir[25:0], 2'b00};
               end
            end
            S_MEM: begin
               if (mem_ready && op == OP_LW) res <= mem_rdata;
            end
            S_WB: begin
               // Register 0 is never written so it always reads as zero.
               if (wb_idx != '0) regs[wb_idx] <= res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed programs for multicycle_core with
// hand-computed results, one default core and one XLEN=64/NREGS=16 core.
module tb_multicycle_core;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   logic rst2;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- DUT 1 (defaults) ----------------
   logic        mem_req, mem_we, mem_ready, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   multicycle_core dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .halted(halted)
   );

   // ---------------- DUT 2 (64-bit, 16 regs, RESET_PC=0x100) ----------------
   logic        mem_req2, mem_we2, mem_ready2, halted2;
   logic [63:0] mem_addr2, mem_wdata2, mem_rdata2;

   multicycle_core #(.XLEN(64), .NREGS(16), .RESET_PC(64'h100)) dut2 (
      .clk(clk), .rst(rst2), .mem_req(mem_req2), .mem_we(mem_we2),
      .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
      .mem_ready(mem_ready2), .halted(halted2)
   );

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- memory model for DUT 1 ----------------
   logic [31:0] imem [0:255];
   logic [31:0] dmem [0:255];
   logic        dval [0:255];
   int          wait_n = 0;
   int          cnt;
   logic [31:0] rd_q[$];
   logic [63:0] exp_q[$];   // expected stores as {addr, data}
   logic [63:0] got_st;

   assign mem_ready = (cnt >= wait_n);
   assign mem_rdata = dval[mem_addr[9:2]] ? dmem[mem_addr[9:2]] : imem[mem_addr[9:2]];

   // request wait counter: ready after wait_n cycles of a pending request
   always @(posedge clk) begin
      if (rst)                      cnt <= 0;
      else if (mem_req && !mem_ready) cnt <= cnt + 1;
      else                          cnt <= 0;
   end

   // monitor: completed reads are logged, completed stores are scoreboarded
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) dval[i] <= 1'b0;
         rd_q.delete();
      end else if (mem_req && mem_ready) begin
         if (mem_we) begin
            dmem[mem_addr[9:2]] <= mem_wdata;
            dval[mem_addr[9:2]] <= 1'b1;
            check("store_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               got_st = {mem_addr, mem_wdata};
               check("store_addr_data", got_st, exp_q.pop_front());
            end
         end else begin
            rd_q.push_back(mem_addr);
         end
      end
   end

   // ---------------- memory model for DUT 2 (zero wait) ----------------
   logic [31:0] imem2 [0:63];
   logic [63:0] st2_addr_q[$];
   logic [63:0] st2_data_q[$];

   assign mem_ready2 = 1'b1;
   assign mem_rdata2 = {32'h0, imem2[mem_addr2[7:2]]};

   always @(negedge clk) begin
      if (!rst2 && mem_req2 && mem_we2) begin
         st2_addr_q.push_back(mem_addr2);
         st2_data_q.push_back(mem_wdata2);
      end
   end

   // ---------------- encoders and driver tasks ----------------
   localparam logic [31:0] HALT = 32'hFC00_0000;
   logic [31:0] prog[$];

   function automatic logic [31:0] enc_r(input int fn, input int rd, input int rs, input int rt);
      return {6'h00, rs[4:0], rt[4:0], rd[4:0], 7'h00, fn[3:0]};
   endfunction

   function automatic logic [31:0] enc_i(input int op, input int rt, input int rs, input int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   function automatic logic [31:0] enc_j(input int target);
      return {6'h05, target[25:0]};
   endfunction

   task automatic load_prog();
      for (int i = 0; i < 256; i++) imem[i] = 32'h0;
      for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
   endtask

   task automatic do_reset(input int w);
      rst    = 1'b1;
      wait_n = w;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // waits for the first fetch, then counts cycles until halted
   task automatic run(input string tag, input int budget, output int cycles);
      int n;
      n = 0;
      while (!mem_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      cycles = n;
      check({tag, "_halted"}, 64'(halted), 64'd1);
   endtask

   // ---------------- test sequence ----------------
   int cycles;
   int n;
   int stab_err;
   int stall_seen;
   logic        prev_req, prev_ready, prev_we;
   logic [31:0] prev_addr;

   initial begin
      rst  = 1'b1;
      rst2 = 1'b1;

      // T1: basic ALU program, latency and flags
      prog = '{enc_i(1, 1, 0, 5), enc_i(1, 2, 0, -3), enc_r(0, 3, 1, 2), HALT};
      load_prog();
      do_reset(0);
      check("t1_rst_req", 64'(mem_req), 64'd0);
      check("t1_rst_halted", 64'(halted), 64'd0);
      check("t1_rst_pc", 64'(dut.pc), 64'd0);
      run("t1", 60, cycles);
      check("t1_cycles", 64'(cycles), 64'd15);
      check("t1_r3", 64'(dut.regs[3]), 64'd2);
      check("t1_z", 64'(dut.flag_z), 64'd0);
      check("t1_c", 64'(dut.flag_c), 64'd1);
      check("t1_s", 64'(dut.flag_s), 64'd0);
      check("t1_v", 64'(dut.flag_v), 64'd0);
      repeat (3) @(negedge clk);
      check("t1_req_after_halt", 64'(mem_req), 64'd0);

      // T2: three wait cycles on every fetch
      prog = '{enc_i(1, 5, 0, 9), HALT};
      load_prog();
      do_reset(3);
      check("t2_rst_clears_halt", 64'(halted), 64'd0);
      n = 0;
      while (!mem_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("t2_first_addr", 64'(mem_addr), 64'd0);
      stab_err = 0;
      stall_seen = 0;
      prev_req = mem_req; prev_ready = mem_ready; prev_we = mem_we; prev_addr = mem_addr;
      n = 0;
      while (!(mem_req && mem_addr == 32'd4) && n < 30) begin
         @(negedge clk);
         n++;
         if (prev_req && !prev_ready) begin
            stall_seen++;
            if (!mem_req || mem_we != prev_we || mem_addr != prev_addr) stab_err++;
         end
         prev_req = mem_req; prev_ready = mem_ready; prev_we = mem_we; prev_addr = mem_addr;
      end
      check("t2_addi_cycles", 64'(n), 64'd7);
      check("t2_stall_cycles", 64'(stall_seen), 64'd3);
      check("t2_stable", 64'(stab_err), 64'd0);
      run("t2", 60, cycles);
      check("t2_r5", 64'(dut.regs[5]), 64'd9);

      // T3a: branch on Z taken
      prog = '{enc_i(1, 1, 0, 1), enc_r(1, 2, 1, 1), enc_i(4, 1, 0, 2),
               enc_i(1, 6, 0, 1), enc_i(1, 6, 0, 2), HALT};
      load_prog();
      do_reset(0);
      run("t3a", 80, cycles);
      check("t3a_z", 64'(dut.flag_z), 64'd1);
      check("t3a_fetch_after_br", 64'(rd_q[3]), 64'd20);
      check("t3a_r6", 64'(dut.regs[6]), 64'd0);

      // T3b: branch on !Z not taken
      prog[2] = enc_i(4, 2, 0, 2);
      load_prog();
      do_reset(0);
      run("t3b", 80, cycles);
      check("t3b_fetch_after_br", 64'(rd_q[3]), 64'd12);
      check("t3b_reads", 64'(rd_q.size()), 64'd6);
      check("t3b_r6", 64'(dut.regs[6]), 64'd2);

      // T4: build 0xDEADBEEF, store it, load it back
      prog = '{enc_i(1, 1, 0, 'hDEAD), enc_i(1, 7, 0, 16), enc_r(5, 1, 1, 7),
               enc_i(1, 8, 0, 'h5EEF), enc_i(1, 8, 8, 'h6000), enc_r(3, 1, 1, 8),
               enc_i(3, 1, 0, 8), enc_i(2, 4, 0, 8), HALT};
      load_prog();
      do_reset(0);
      exp_q.push_back({32'd8, 32'hDEAD_BEEF});
      run("t4", 120, cycles);
      check("t4_r4", 64'(dut.regs[4]), 64'hDEAD_BEEF);
      check("t4_lw_addr", 64'(rd_q[8]), 64'd8);
      check("t4_store_pending", 64'(exp_q.size()), 64'd0);

      // T5: signed overflow on add
      prog = '{enc_i(1, 1, 0, -1), enc_i(1, 2, 0, 1), enc_r(6, 1, 1, 2),
               enc_r(0, 3, 1, 2), HALT};
      load_prog();
      do_reset(1);
      run("t5", 120, cycles);
      check("t5_r3", 64'(dut.regs[3]), 64'h8000_0000);
      check("t5_v", 64'(dut.flag_v), 64'd1);
      check("t5_s", 64'(dut.flag_s), 64'd1);
      check("t5_c", 64'(dut.flag_c), 64'd0);
      check("t5_z", 64'(dut.flag_z), 64'd0);

      // T6: write to r0 dropped, 0-1 borrow
      prog = '{enc_i(1, 2, 0, 1), enc_i(1, 0, 0, 5), enc_i(3, 0, 0, 'h20),
               enc_r(1, 4, 0, 2), HALT};
      load_prog();
      do_reset(0);
      exp_q.push_back({32'h20, 32'h0});
      run("t6", 80, cycles);
      check("t6_r0", 64'(dut.regs[0]), 64'd0);
      check("t6_r4", 64'(dut.regs[4]), 64'hFFFF_FFFF);
      check("t6_c", 64'(dut.flag_c), 64'd1);
      check("t6_v", 64'(dut.flag_v), 64'd0);
      check("t6_s", 64'(dut.flag_s), 64'd1);
      check("t6_store_pending", 64'(exp_q.size()), 64'd0);

      // T7: jump and two kinds of NOP
      prog = '{enc_j(5), enc_i(1, 9, 0, 9), 32'h0, 32'h0, 32'h0,
               enc_i(1, 3, 0, 3), enc_i(16, 0, 0, 0), enc_r(9, 3, 3, 3), HALT};
      load_prog();
      do_reset(0);
      run("t7", 80, cycles);
      check("t7_cycles", 64'(cycles), 64'd16);
      check("t7_jump_target", 64'(rd_q[1]), 64'd20);
      check("t7_r3", 64'(dut.regs[3]), 64'd3);
      check("t7_r9", 64'(dut.regs[9]), 64'd0);

      // T8: reset during a stalled store
      prog = '{enc_i(3, 0, 0, 'h40), HALT};
      load_prog();
      do_reset(5);
      n = 0;
      while (!(mem_req && mem_we) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("t8_store_req", 64'(mem_we && mem_req), 64'd1);
      check("t8_store_addr", 64'(mem_addr), 64'h40);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t8_req_drop", 64'(mem_req), 64'd0);
      @(negedge clk);
      check("t8_refetch_req", 64'(mem_req), 64'd1);
      check("t8_refetch_addr", 64'(mem_addr), 64'd0);
      check("t8_refetch_we", 64'(mem_we), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("t8_store_pending", 64'(exp_q.size()), 64'd0);

      // T9: XLEN=64, NREGS=16 with register-field aliasing
      for (int i = 0; i < 64; i++) imem2[i] = 32'h0;
      imem2[0] = enc_i(1, 1, 0, 7);
      imem2[1] = enc_i(1, 18, 17, 1);
      imem2[2] = enc_r(1, 3, 0, 1);
      imem2[3] = enc_i(3, 2, 0, 'h40);
      imem2[4] = HALT;
      rst2 = 1'b0;
      check("t9_rst_req", 64'(mem_req2), 64'd0);
      n = 0;
      while (!mem_req2 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("t9_first_fetch", mem_addr2, 64'h100);
      n = 0;
      while (!halted2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t9_halted", 64'(halted2), 64'd1);
      check("t9_stores", 64'(st2_addr_q.size()), 64'd1);
      check("t9_store_addr", (st2_addr_q.size() != 0) ? st2_addr_q[0] : 64'hX, 64'h40);
      check("t9_store_data", (st2_data_q.size() != 0) ? st2_data_q[0] : 64'hX, 64'd8);
      check("t9_r3", dut2.regs[3], 64'hFFFF_FFFF_FFFF_FFF9);
      check("t9_c", 64'(dut2.flag_c), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // watchdog so the run always ends
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
